jk_ff_exerciser: RTL and testbench

- Synthesizable initiator that drives the j/k inputs of a master-slave JK flip-flop under test and reads back q/qn.
- Steps the flop through a fixed excitation sequence: clear, hold-0, set, hold-1, toggle, clear.
- Checks the flop's response against an internal JK model and reports pass/fail plus a saturating error count.
- Sits on the board next to m_s_ff, so the flop can be exercised on hardware without a simulator bench.

---
 rtl/jk_ff_exerciser.sv | 142 ++++++++++++++
 tb/tb_jk_ff_exerciser.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_ff_exerciser.sv
// On-board exerciser for a master-slave JK flop: drives a fixed
// j/k excitation sequence, checks q/qn and counts errors.
module jk_ff_exerciser #(
  parameter int HOLD_CYCLES = 10,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             j_out,
  output logic             k_out,
  input  logic             q_in,
  input  logic             qn_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [2:0]       phase
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT   = 3'd1,
    HOLD0  = 3'd2,
    SET    = 3'd3,
    HOLD1  = 3'd4,
    TOGGLE = 3'd5,
    CLEAR  = 3'd6,
    DONE   = 3'd7
  } state_t;

  localparam int         EW1  = ERR_W + 1;
  localparam logic [7:0] LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] TMIN = 8'(HOLD_CYCLES - 3);

  state_t     state;
  state_t     nxt;
  logic [7:0] cnt;
  logic [7:0] tcnt;
  logic [7:0] tsum;
  logic       q_s;
  logic       qn_s;
  logic       q_p;
  logic       last;
  logic       lvl_err;
  logic       tog_err;
  logic       cmp_err;
  logic [1:0] inc;
  logic [EW1-1:0]   esum;
  logic [ERR_W-1:0] esat;
  logic [1:0] jk_nxt;

  assign phase = state;
  assign pass  = done && (err_count == '0);
  assign last  = (cnt == LAST);
  assign nxt   = state_t'(state + 3'd1);
  assign tsum  = tcnt + {7'd0, q_s ^ q_p};

  always_comb begin
    lvl_err = 1'b0;
    if (last) begin
      unique case (state)
        HOLD0:   lvl_err = q_s;
        SET:     lvl_err = !q_s;
        HOLD1:   lvl_err = !q_s;
        CLEAR:   lvl_err = q_s;
        default: lvl_err = 1'b0;
      endcase
    end
  end

  // INIT's first two cycles still see the flop's unknown start state
  assign tog_err = (state == TOGGLE) && last && (tsum < TMIN);
  assign cmp_err = busy && (qn_s == q_s) &&
                   !((state == INIT) && (cnt < 8'd2));

  assign inc  = {1'b0, lvl_err} + {1'b0, tog_err} + {1'b0, cmp_err};
  assign esum = {1'b0, err_count} + EW1'(inc);
  assign esat = esum[ERR_W] ? '1 : esum[ERR_W-1:0];

  always_comb begin
    jk_nxt = 2'b00;
    unique case (nxt)
      INIT:    jk_nxt = 2'b01;
      SET:     jk_nxt = 2'b10;
      TOGGLE:  jk_nxt = 2'b11;
      CLEAR:   jk_nxt = 2'b01;
      default: jk_nxt = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      tcnt      <= '0;
      q_s       <= 1'b0;
      qn_s      <= 1'b0;
      q_p       <= 1'b0;
      j_out     <= 1'b0;
      k_out     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_count <= '0;
    end else begin
      q_s  <= q_in;
      qn_s <= qn_in;
      q_p  <= q_s;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= INIT;
            cnt       <= '0;
            tcnt      <= '0;
            err_count <= '0;
            j_out     <= 1'b0;
            k_out     <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
          end
        end
        default: begin
          err_count <= esat;
          if ((state == TOGGLE) && (q_s != q_p))
            tcnt <= tcnt + 8'd1;
          if (last) begin
            state <= nxt;
            cnt   <= '0;
            tcnt  <= '0;
            j_out <= jk_nxt[1];
            k_out <= jk_nxt[0];
            busy  <= (nxt != DONE);
            done  <= (nxt == DONE);
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jk_ff_exerciser.sv
// Bench for jk_ff_exerciser: behavioural JK flop with fault modes,
// scoreboard of expected drive/results per run.
module tb_jk_ff_exerciser;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       j_out, k_out, q_in, qn_in;
  logic       busy, done, pass;
  logic [7:0] err_count;
  logic [2:0] phase;

  logic       start2 = 1'b0;
  logic       j2, k2, q2, qn2, busy2, done2, pass2;
  logic [7:0] err2;
  logic [2:0] phase2;

  // 0 good, 1 q stuck-at-0, 2 qn tied to q, 3 ignores toggle
  int mode = 0;
  logic fq, fq2;

  int total = 0;
  int bad = 0;

  typedef struct {
    int err;
    bit pas;
    int lat;
  } res_t;

  res_t       res_q[$];
  logic [1:0] jk_q[$];

  always #5 clk = ~clk;

  jk_ff_exerciser #(.HOLD_CYCLES(10), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .j_out(j_out), .k_out(k_out),
    .q_in(q_in), .qn_in(qn_in),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .phase(phase)
  );

  jk_ff_exerciser #(.HOLD_CYCLES(100), .ERR_W(8)) dut2 (
    .clk(clk), .rst(rst), .start(start2),
    .j_out(j2), .k_out(k2),
    .q_in(q2), .qn_in(qn2),
    .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .phase(phase2)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fq <= 1'b0;
    else begin
      case ({j_out, k_out})
        2'b01: fq <= 1'b0;
        2'b10: fq <= 1'b1;
        2'b11: if (mode != 3) fq <= ~fq;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fq2 <= 1'b0;
    else begin
      case ({j2, k2})
        2'b01: fq2 <= 1'b0;
        2'b10: fq2 <= 1'b1;
        2'b11: fq2 <= ~fq2;
        default: ;
      endcase
    end
  end

  assign q_in  = (mode == 1) ? 1'b0 : fq;
  assign qn_in = (mode == 2) ? q_in : ~q_in;
  assign q2    = fq2;
  assign qn2   = fq2;

  task automatic run(input string nm, input int exp_err,
                     input bit exp_pass, input int mid_start,
                     input bit chk_restart);
    logic [1:0] tbl [6];
    res_t r;
    int n;
    tbl = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b11, 2'b01};
    jk_q.delete();
    for (int i = 0; i < 6; i++) jk_q.push_back(tbl[i]);
    res_q.push_back('{exp_err, exp_pass, 60});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (chk_restart) begin
      total++;
      if (done !== 1'b0 || busy !== 1'b1 || err_count !== 8'd0 ||
          phase !== 3'd1) begin
        bad++;
        $display("FAIL %s restart: done=%b busy=%b err=%0d ph=%0d want 0 1 0 1",
                 nm, done, busy, err_count, phase);
      end
    end
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
      start = (n == mid_start);
      if (n % 10 == 5 && n < 60 && jk_q.size() > 0) begin
        logic [1:0] e;
        e = jk_q.pop_front();
        total++;
        if ({j_out, k_out} !== e) begin
          bad++;
          $display("FAIL %s jk@%0d: got %b want %b", nm, n,
                   {j_out, k_out}, e);
        end
      end
    end
    start = 1'b0;
    r = res_q.pop_front();
    total++;
    if (n !== r.lat) begin
      bad++;
      $display("FAIL %s latency: got %0d want %0d", nm, n, r.lat);
    end
    total++;
    if (err_count !== r.err[7:0]) begin
      bad++;
      $display("FAIL %s err_count: got %0d want %0d", nm, err_count, r.err);
    end
    total++;
    if (pass !== r.pas) begin
      bad++;
      $display("FAIL %s pass: got %b want %b", nm, pass, r.pas);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({j_out, k_out, busy, done, pass} !== 5'b0 || err_count !== 8'd0 ||
        phase !== 3'd0) begin
      bad++;
      $display("FAIL reset: jkbdp=%b err=%0d ph=%0d want 0",
               {j_out, k_out, busy, done, pass}, err_count, phase);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_clean();
    mode = 0;
    run("clean", 0, 1'b1, 0, 1'b0);
  endtask

  task automatic test_stuck0_then_restart();
    mode = 1;
    run("stuck0", 3, 1'b0, 0, 1'b0);
    mode = 0;
    run("restart_from_done", 0, 1'b1, 0, 1'b1);
  endtask

  task automatic test_qn_eq_q();
    mode = 2;
    run("qn_eq_q", 58, 1'b0, 0, 1'b0);
  endtask

  task automatic test_no_toggle();
    mode = 3;
    run("no_toggle", 1, 1'b0, 0, 1'b0);
  endtask

  task automatic test_start_in_toggle();
    mode = 0;
    run("start_in_toggle", 0, 1'b1, 45, 1'b0);
  endtask

  task automatic test_reset_mid_run();
    mode = 2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (25) @(negedge clk);
    total++;
    if (err_count === 8'd0 || phase !== 3'd3) begin
      bad++;
      $display("FAIL midrun_pre: err=%0d ph=%0d want nonzero and 3",
               err_count, phase);
    end
    rst = 1'b0;
    #1;
    total++;
    if ({j_out, k_out, busy, done} !== 4'b0 || err_count !== 8'd0 ||
        phase !== 3'd0) begin
      bad++;
      $display("FAIL midrun_abort: jkbd=%b err=%0d ph=%0d want 0",
               {j_out, k_out, busy, done}, err_count, phase);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    mode = 0;
    @(negedge clk);
    run("clean_after_rst", 0, 1'b1, 0, 1'b0);
  endtask

  task automatic test_saturate();
    int n;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    n = 0;
    while (done2 !== 1'b1 && n < 800) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n !== 600) begin
      bad++;
      $display("FAIL sat latency: got %0d want 600", n);
    end
    total++;
    if (err2 !== 8'd255 || pass2 !== 1'b0) begin
      bad++;
      $display("FAIL sat err: got %0d pass=%b want 255 0", err2, pass2);
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_stuck0_then_restart();
    test_qn_eq_q();
    test_no_toggle();
    test_start_in_toggle();
    test_reset_mid_run();
    test_saturate();
    total++;
    if ({j_out, k_out} !== 2'b00 || done !== 1'b1) begin
      bad++;
      $display("FAIL done_idle_drive: jk=%b done=%b want 00 1",
               {j_out, k_out}, done);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
